// File: rtl/i2c_pkg.sv
// Shared types and bus constants for the I2C target controller.
package i2c_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        WR_BYTE,
        WR_ACK,
        RD_BYTE,
        RD_ACK,
        WAIT_STOP
    } state_t;

    localparam logic I2C_ACK  = 1'b0;
    localparam logic I2C_NACK = 1'b1;
    localparam logic I2C_RD   = 1'b1;
    localparam logic I2C_WR   = 1'b0;

    function automatic logic addr_match(input logic [7:0] addr_byte, input logic [6:0] own_addr);
        return addr_byte[7:1] == own_addr;
    endfunction

endpackage

// File: rtl/i2c_sync_edge.sv
// Multi-flop synchronizer for one asynchronous bus line plus registered-level edge strobes.
module i2c_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic lvl_o,
    output logic rise_o,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_q, prev_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], d_i};
        prev_d = sync_q[SYNC_STAGES-1];
    end

    // Reset to the idle-high bus level so leaving reset never fakes an edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '1;
            prev_q <= 1'b1;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign lvl_o  = sync_q[SYNC_STAGES-1];
    assign rise_o = lvl_o & ~prev_q;
    assign fall_o = ~lvl_o & prev_q;

endmodule

// File: rtl/i2c_slave_ctrl.sv
// I2C target: START/STOP detect, 7-bit address match, byte write/read with a local byte side.
//  state     | meaning
//  IDLE      | bus free, waiting for START
//  ADDR      | shifting in the address/RW byte
//  ADDR_ACK  | holding ACK for our address
//  WR_BYTE   | shifting in a write data byte
//  WR_ACK    | holding ACK for a written byte
//  RD_BYTE   | driving a read data byte
//  RD_ACK    | sampling initiator ACK/NACK for a read byte
//  WAIT_STOP | not addressed or read ended, idle until START/STOP
module i2c_slave_ctrl
    import i2c_pkg::*;
#(
    parameter logic [6:0] SLAVE_ADDR  = 7'h50,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       sda_oe,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       tx_req,
    input  logic [7:0] tx_data,
    output logic       rd_nack,
    output logic       busy
);

    logic scl_s, scl_rise, scl_fall;
    logic sda_s, sda_rise, sda_fall;
    logic start_det, stop_det;

    i2c_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_scl (
        .clk(clk), .rst(rst), .d_i(scl_i),
        .lvl_o(scl_s), .rise_o(scl_rise), .fall_o(scl_fall)
    );

    i2c_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sda (
        .clk(clk), .rst(rst), .d_i(sda_i),
        .lvl_o(sda_s), .rise_o(sda_rise), .fall_o(sda_fall)
    );

    assign start_det = sda_fall & scl_s;
    assign stop_det  = sda_rise & scl_s;

    state_t     state_q, state_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic       byte_done_q, byte_done_d;
    logic [7:0] rx_sr_q, rx_sr_d;
    logic [7:0] tx_sr_q, tx_sr_d;
    logic       rw_q, rw_d;
    logic       rx_pend_q, rx_pend_d;
    logic       sda_oe_q, sda_oe_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       rx_valid_q, rx_valid_d;
    logic       tx_req_q, tx_req_d;
    logic       rd_nack_q, rd_nack_d;
    logic       busy_q, busy_d;

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        byte_done_d = byte_done_q;
        rx_sr_d     = rx_sr_q;
        tx_sr_d     = tx_sr_q;
        rw_d        = rw_q;
        rx_pend_d   = 1'b0;
        sda_oe_d    = sda_oe_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        tx_req_d    = 1'b0;
        rd_nack_d   = 1'b0;
        busy_d      = busy_q;

        // Read byte is taken from the local side one clk after the request.
        if (tx_req_q) tx_sr_d = tx_data;

        if (rx_pend_q) begin
            rx_data_d  = rx_sr_q;
            rx_valid_d = 1'b1;
        end

        if (start_det) begin
            state_d     = ADDR;
            bit_cnt_d   = 3'd0;
            byte_done_d = 1'b0;
            sda_oe_d    = 1'b0;
            busy_d      = 1'b1;
        end else if (stop_det) begin
            state_d     = IDLE;
            byte_done_d = 1'b0;
            sda_oe_d    = 1'b0;
            busy_d      = 1'b0;
        end else begin
            case (state_q)
                IDLE: ;
                ADDR, WR_BYTE: begin
                    if (scl_rise) begin
                        rx_sr_d   = {rx_sr_q[6:0], sda_s};
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            byte_done_d = 1'b1;
                            rx_pend_d   = (state_q == WR_BYTE);
                        end
                    end else if (scl_fall && byte_done_q) begin
                        byte_done_d = 1'b0;
                        if (state_q == WR_BYTE) begin
                            sda_oe_d = 1'b1;
                            state_d  = WR_ACK;
                        end else if (addr_match(rx_sr_q, SLAVE_ADDR)) begin
                            sda_oe_d = 1'b1;
                            rw_d     = rx_sr_q[0];
                            tx_req_d = (rx_sr_q[0] == I2C_RD);
                            state_d  = ADDR_ACK;
                        end else begin
                            sda_oe_d = 1'b0;
                            state_d  = WAIT_STOP;
                        end
                    end
                end
                ADDR_ACK: begin
                    if (scl_fall) begin
                        bit_cnt_d = 3'd0;
                        if (rw_q == I2C_RD) begin
                            sda_oe_d = ~tx_sr_q[7];
                            state_d  = RD_BYTE;
                        end else begin
                            sda_oe_d = 1'b0;
                            state_d  = WR_BYTE;
                        end
                    end
                end
                WR_ACK: begin
                    if (scl_fall) begin
                        sda_oe_d  = 1'b0;
                        bit_cnt_d = 3'd0;
                        state_d   = WR_BYTE;
                    end
                end
                RD_BYTE: begin
                    if (scl_rise) begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) byte_done_d = 1'b1;
                    end else if (scl_fall) begin
                        if (byte_done_q) begin
                            byte_done_d = 1'b0;
                            sda_oe_d    = 1'b0;
                            state_d     = RD_ACK;
                        end else begin
                            sda_oe_d = ~tx_sr_q[3'd7 - bit_cnt_q];
                        end
                    end
                end
                RD_ACK: begin
                    if (scl_rise) begin
                        if (sda_s == I2C_ACK) begin
                            tx_req_d = 1'b1;
                        end else begin
                            rd_nack_d = 1'b1;
                            state_d   = WAIT_STOP;
                        end
                    end else if (scl_fall) begin
                        bit_cnt_d = 3'd0;
                        sda_oe_d  = ~tx_sr_q[7];
                        state_d   = RD_BYTE;
                    end
                end
                WAIT_STOP: sda_oe_d = 1'b0;
                default:   state_d  = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            bit_cnt_q   <= 3'd0;
            byte_done_q <= 1'b0;
            rx_sr_q     <= 8'h00;
            tx_sr_q     <= 8'h00;
            rw_q        <= I2C_WR;
            rx_pend_q   <= 1'b0;
            sda_oe_q    <= 1'b0;
            rx_data_q   <= 8'h00;
            rx_valid_q  <= 1'b0;
            tx_req_q    <= 1'b0;
            rd_nack_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            byte_done_q <= byte_done_d;
            rx_sr_q     <= rx_sr_d;
            tx_sr_q     <= tx_sr_d;
            rw_q        <= rw_d;
            rx_pend_q   <= rx_pend_d;
            sda_oe_q    <= sda_oe_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            tx_req_q    <= tx_req_d;
            rd_nack_q   <= rd_nack_d;
            busy_q      <= busy_d;
        end
    end

    assign sda_oe   = sda_oe_q;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign tx_req   = tx_req_q;
    assign rd_nack  = rd_nack_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_i2c_slave_ctrl.sv
// Bench for i2c_slave_ctrl: bit-banged initiator on an open-drain SDA, table of transfers plus corner sequences.
module tb_i2c_slave_ctrl;

    localparam int Q = 10;  // clk cycles per quarter SCL period

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       scl_m = 1'b1;
    logic       sda_m = 1'b1;
    logic       sda_bus;
    logic       sda_oe;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       tx_req;
    logic [7:0] tx_data = 8'h00;
    logic       rd_nack;
    logic       busy;

    assign sda_bus = sda_m & ~sda_oe;

    i2c_slave_ctrl #(.SLAVE_ADDR(7'h50), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .scl_i(scl_m), .sda_i(sda_bus),
        .sda_oe(sda_oe), .rx_data(rx_data), .rx_valid(rx_valid),
        .tx_req(tx_req), .tx_data(tx_data), .rd_nack(rd_nack), .busy(busy)
    );

    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_pass = 0;
    logic [7:0] rx_log[$];
    logic [7:0] tx_q[$];
    int         tx_req_cnt = 0;
    int         rd_nack_cnt = 0;

    // Local side: log written bytes, answer read requests from tx_q.
    always @(negedge clk) begin
        if (rx_valid) rx_log.push_back(rx_data);
        if (rd_nack) rd_nack_cnt++;
        if (tx_req) begin
            tx_req_cnt++;
            tx_data = (tx_q.size() > 0) ? tx_q.pop_front() : 8'hEE;
        end
    end

    typedef struct {
        logic [7:0]      addr;
        int              n;
        logic [1:0][7:0] d;
        logic            ack_exp;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_start();
        sda_m = 1'b0; wait_clks(Q);
        scl_m = 1'b0; wait_clks(Q);
    endtask

    task automatic bus_rep_start();
        sda_m = 1'b1; wait_clks(Q);
        scl_m = 1'b1; wait_clks(Q);
        sda_m = 1'b0; wait_clks(Q);
        scl_m = 1'b0; wait_clks(Q);
    endtask

    task automatic bus_stop();
        sda_m = 1'b0; wait_clks(Q);
        scl_m = 1'b1; wait_clks(Q);
        sda_m = 1'b1; wait_clks(Q);
    endtask

    task automatic write_bit(input logic b);
        sda_m = b;    wait_clks(Q);
        scl_m = 1'b1; wait_clks(2 * Q);
        scl_m = 1'b0; wait_clks(Q);
    endtask

    task automatic read_bit(output logic b);
        sda_m = 1'b1; wait_clks(Q);
        scl_m = 1'b1; wait_clks(Q);
        b = sda_bus;  wait_clks(Q);
        scl_m = 1'b0; wait_clks(Q);
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        for (int i = 7; i >= 0; i--) write_bit(d[i]);
        read_bit(ack);
    endtask

    task automatic read_byte(output logic [7:0] d, input logic nack);
        logic b;
        d = 8'h00;
        for (int i = 0; i < 8; i++) begin
            read_bit(b);
            d = {d[6:0], b};
        end
        write_bit(nack);
    endtask

    task automatic run_vec(input vec_t v);
        int         rx_base, txr_base, nk_base;
        logic       ack;
        logic [7:0] rd;
        logic       rd_xfer;
        rx_base  = rx_log.size();
        txr_base = tx_req_cnt;
        nk_base  = rd_nack_cnt;
        rd_xfer  = v.addr[0];
        tx_q.delete();
        for (int i = 0; i < v.n; i++) tx_q.push_back(v.d[i]);
        bus_start();
        write_byte(v.addr, ack);
        check("addr_ack", 32'(ack), 32'(v.ack_exp));
        check("busy_mid", 32'(busy), 32'd1);
        if (v.ack_exp) begin
            write_byte(v.d[0], ack);
            check("ignored_byte_ack", 32'(ack), 32'd1);
        end else if (!rd_xfer) begin
            for (int i = 0; i < v.n; i++) begin
                write_byte(v.d[i], ack);
                check("wr_byte_ack", 32'(ack), 32'd0);
            end
        end else begin
            for (int i = 0; i < v.n; i++) begin
                read_byte(rd, (i == v.n - 1));
                check("rd_byte_data", 32'(rd), 32'(v.d[i]));
            end
        end
        bus_stop();
        wait_clks(Q);
        check("busy_after_stop", 32'(busy), 32'd0);
        check("sda_oe_after_stop", 32'(sda_oe), 32'd0);
        if (!v.ack_exp && !rd_xfer) begin
            check("rx_count", 32'(rx_log.size() - rx_base), 32'(v.n));
            for (int i = 0; i < v.n; i++)
                if (rx_log.size() > rx_base + i)
                    check("rx_data", 32'(rx_log[rx_base + i]), 32'(v.d[i]));
        end else begin
            check("rx_count", 32'(rx_log.size() - rx_base), 32'd0);
        end
        check("tx_req_count", 32'(tx_req_cnt - txr_base), (!v.ack_exp && rd_xfer) ? 32'(v.n) : 32'd0);
        check("rd_nack_count", 32'(rd_nack_cnt - nk_base), (!v.ack_exp && rd_xfer) ? 32'd1 : 32'd0);
    endtask

    initial begin
        int         rx_base, txr_base, nk_base;
        logic       ack;
        logic [7:0] rd;
        logic [7:0] addr_w;

        vecs[0] = '{addr: 8'hA0, n: 2, d: {8'hFF, 8'h3C}, ack_exp: 1'b0};
        vecs[1] = '{addr: 8'h84, n: 1, d: {8'h00, 8'h55}, ack_exp: 1'b1};
        vecs[2] = '{addr: 8'hA1, n: 2, d: {8'hC3, 8'h5A}, ack_exp: 1'b0};
        vecs[3] = '{addr: 8'hA0, n: 1, d: {8'h00, 8'h00}, ack_exp: 1'b0};
        vecs[4] = '{addr: 8'hA1, n: 1, d: {8'h00, 8'h80}, ack_exp: 1'b0};
        vecs[5] = '{addr: 8'hA3, n: 1, d: {8'h00, 8'h12}, ack_exp: 1'b1};
        vecs[6] = '{addr: 8'hA0, n: 2, d: {8'hAA, 8'h55}, ack_exp: 1'b0};

        wait_clks(5);
        rst = 1'b0;
        wait_clks(5);
        check("rst_sda_oe", 32'(sda_oe), 32'd0);
        check("rst_rx_data", 32'(rx_data), 32'h00);
        check("rst_rx_valid", 32'(rx_valid), 32'd0);
        check("rst_tx_req", 32'(tx_req), 32'd0);
        check("rst_rd_nack", 32'(rd_nack), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);

        // SCL toggling with no START must leave the target idle.
        rx_base = rx_log.size();
        for (int i = 0; i < 4; i++) begin
            scl_m = 1'b0; wait_clks(Q);
            sda_m = i[0]; wait_clks(Q);
            scl_m = 1'b1; wait_clks(2 * Q);
        end
        sda_m = 1'b1;
        scl_m = 1'b0; wait_clks(Q);
        sda_m = 1'b1; wait_clks(Q);
        scl_m = 1'b1; wait_clks(2 * Q);
        check("idle_scl_busy", 32'(busy), 32'd0);
        check("idle_scl_sda_oe", 32'(sda_oe), 32'd0);
        check("idle_scl_rx", 32'(rx_log.size() - rx_base), 32'd0);

        for (int i = 0; i < 7; i++) run_vec(vecs[i]);

        // Write then repeated START into a read, no STOP between.
        rx_base  = rx_log.size();
        txr_base = tx_req_cnt;
        nk_base  = rd_nack_cnt;
        tx_q.delete();
        bus_start();
        write_byte(8'hA0, ack);
        check("rs_addr_w_ack", 32'(ack), 32'd0);
        write_byte(8'h10, ack);
        check("rs_data_ack", 32'(ack), 32'd0);
        tx_q.push_back(8'h7E);
        bus_rep_start();
        check("rs_busy_after_rs", 32'(busy), 32'd1);
        write_byte(8'hA1, ack);
        check("rs_addr_r_ack", 32'(ack), 32'd0);
        read_byte(rd, 1'b1);
        check("rs_rd_data", 32'(rd), 32'h7E);
        bus_stop();
        wait_clks(Q);
        check("rs_rx_count", 32'(rx_log.size() - rx_base), 32'd1);
        if (rx_log.size() > rx_base) check("rs_rx_data", 32'(rx_log[rx_base]), 32'h10);
        check("rs_tx_req", 32'(tx_req_cnt - txr_base), 32'd1);
        check("rs_rd_nack", 32'(rd_nack_cnt - nk_base), 32'd1);
        check("rs_busy_end", 32'(busy), 32'd0);

        // STOP after 4 data bits of a write byte.
        rx_base = rx_log.size();
        bus_start();
        write_byte(8'hA0, ack);
        check("ps_addr_ack", 32'(ack), 32'd0);
        write_bit(1'b1); write_bit(1'b0); write_bit(1'b1); write_bit(1'b1);
        bus_stop();
        wait_clks(Q);
        check("ps_busy", 32'(busy), 32'd0);
        check("ps_sda_oe", 32'(sda_oe), 32'd0);
        check("ps_rx_count", 32'(rx_log.size() - rx_base), 32'd0);

        // Reset while the target holds the address ACK low.
        addr_w = 8'hA0;
        bus_start();
        for (int i = 7; i >= 0; i--) write_bit(addr_w[i]);
        check("rr_ack_held", 32'(sda_oe), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rr_sda_oe_released", 32'(sda_oe), 32'd0);
        check("rr_busy_cleared", 32'(busy), 32'd0);
        sda_m = 1'b1; wait_clks(Q);
        scl_m = 1'b1; wait_clks(2 * Q);
        run_vec(vecs[0]);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
